// File: rtl/acc_stream_if.sv
// Valid/ready operand stream in, packet result stream out, for acc_stream.
interface acc_stream_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/acc_stream.sv
// Streaming packet accumulator with an internal ripple/look-ahead adder.
// Define ACC_STREAM_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module adder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ALGORITHM = 0
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH:0]   sum
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g   = in0 & in1;
  assign p   = in0 ^ in1;
  assign sum = {c[WIDTH], p ^ c[WIDTH-1:0]};

  if (ALGORITHM == 1) begin : g_cla
    // Each carry is expanded directly from generate/propagate terms.
    always_comb begin
      logic term;
      term = 1'b0;
      c    = '0;
      for (int i = 1; i <= int'(WIDTH); i++) begin
        for (int j = 0; j < i; j++) begin
          term = g[j];
          for (int k = j + 1; k < i; k++) begin
            term = term & p[k];
          end
          c[i] = c[i] | term;
        end
      end
    end
  end else begin : g_ripple
    assign c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign c[i+1] = g[i] | (p[i] & c[i]);
    end
  end
endmodule

module acc_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned ALGORITHM = 0,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  acc_stream_if.slave bus
);
  if (ACC_WIDTH < WIDTH) begin : g_bad_width
    $error("acc_stream: ACC_WIDTH must be >= WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH:0]   sum;
  logic                 beat;

  assign operand = ACC_WIDTH'(bus.in_data);
  assign beat    = bus.in_valid && (state_q != StHold);

  adder #(
    .WIDTH     (ACC_WIDTH),
    .ALGORITHM (ALGORITHM)
  ) u_adder (
    .in0 (acc_q),
    .in1 (operand),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (beat) state_d = bus.in_last ? StHold : StAcc;
      StAcc:   if (beat && bus.in_last) state_d = StHold;
      StHold:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Both handshake outputs are pure state decodes.
  always_comb begin
    bus.in_ready  = (state_q != StHold);
    bus.out_valid = (state_q == StHold);
    bus.out_data  = '0;
    bus.out_count = '0;
    bus.out_ovf   = 1'b0;
    if (state_q == StHold) begin
      bus.out_data  = acc_q;
      bus.out_count = cnt_q;
      bus.out_ovf   = ovf_q;
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          acc_d = operand;
          cnt_d = CNT_WIDTH'(1);
          ovf_d = 1'b0;
        end
      end
      StAcc: begin
        if (beat) begin
          acc_d = sum[ACC_WIDTH-1:0];
          if (sum[ACC_WIDTH]) begin
            ovf_d = 1'b1;
`ifdef ACC_STREAM_SAT_EN
            acc_d = '1;
`endif
          end
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      default: begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
